ctrl_pipe: RTL

Control pipeline and hazard unit for the 5-stage MIPS CPU. It receives the decoded control bundle from the main control decoder in ID and carries it through the ID/EX, EX/MEM and MEM/WB registers to the datapath consumers. It also detects load-use hazards, resolves BEQ/BNE in EX, generates forwarding selects and handles the STOP (opcode 63) halt sequence.

---
 rtl/ctrl_pipe.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control pipeline (ID/EX, EX/MEM, MEM/WB) and hazard unit.
// Define CTRL_PIPE_FWD_EN for forwarding; otherwise RAW hazards stall.
module ctrl_pipe #(
  parameter int REG_W = 5,
  parameter int ALU_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_stop,
  input  logic             id_reg_write_en,
  input  logic             id_mem2reg_sel,
  input  logic             id_mem_write_en,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             id_reg_dst,
  input  logic [ALU_W-1:0] id_alu_ctrl,
  input  logic [ALU_W-1:0] id_alu_src,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_zero,
  output logic [ALU_W-1:0] ex_alu_ctrl,
  output logic [ALU_W-1:0] ex_alu_src,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic             mem_write_en,
  output logic             mem_mem2reg_sel,
  output logic             wb_reg_write_en,
  output logic             wb_mem2reg_sel,
  output logic [REG_W-1:0] wb_dest,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             flush,
  output logic             branch_taken,
  output logic             halted
);

  typedef struct packed {
    logic             rw;
    logic             m2r;
    logic             mw;
    logic             beq;
    logic             bne;
    logic [ALU_W-1:0] alu;
    logic [ALU_W-1:0] src;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             stop;
  } id_ex_t;

  typedef struct packed {
    logic             rw;
    logic             m2r;
    logic             mw;
    logic [REG_W-1:0] dest;
    logic             stop;
  } ex_mem_t;

  typedef struct packed {
    logic             rw;
    logic             m2r;
    logic [REG_W-1:0] dest;
    logic             stop;
  } mem_wb_t;

  id_ex_t  ide, ide_nxt;
  ex_mem_t exm;
  mem_wb_t mwb;

  logic load_use;
  logic raw;
  logic stop_busy;

  // register 0 is never a dependency
  function automatic logic hit(
    input logic             w,
    input logic [REG_W-1:0] d,
    input logic [REG_W-1:0] r
  );
    return w & (d != '0) & (d == r);
  endfunction

`ifdef CTRL_PIPE_FWD_EN
  function automatic logic [1:0] fsel(
    input logic [REG_W-1:0] r
  );
    if (hit(exm.rw, exm.dest, r))
      return 2'b10;
    if (hit(mwb.rw, mwb.dest, r))
      return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a = fsel(ide.rs);
  assign fwd_b = fsel(ide.rt);
  assign raw   = 1'b0;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
  assign raw   = id_valid &
    (hit(ide.rw, ide.dest, id_rs) |
     hit(ide.rw, ide.dest, id_rt) |
     hit(exm.rw, exm.dest, id_rs) |
     hit(exm.rw, exm.dest, id_rt));
`endif

  assign branch_taken = (ide.beq & ex_zero) |
                        (ide.bne & ~ex_zero);
  assign flush = branch_taken;

  assign load_use = id_valid & ide.m2r &
    (hit(ide.rw, ide.dest, id_rs) |
     hit(ide.rw, ide.dest, id_rt));

  assign stop_busy = ide.stop | exm.stop |
                     mwb.stop | halted;

  assign stall = ~branch_taken &
                 (load_use | raw | stop_busy);

  assign ex_alu_ctrl     = ide.alu;
  assign ex_alu_src      = ide.src;
  assign ex_rs           = ide.rs;
  assign ex_rt           = ide.rt;
  assign mem_write_en    = exm.mw;
  assign mem_mem2reg_sel = exm.m2r;
  assign wb_reg_write_en = mwb.rw;
  assign wb_mem2reg_sel  = mwb.m2r;
  assign wb_dest         = mwb.dest;

  // next ID/EX entry: bubble, stop marker or decoded bundle
  always_comb begin
    ide_nxt = '0;
    if (id_valid & ~stall & ~flush) begin
      if (id_stop) begin
        ide_nxt.stop = 1'b1;
      end else begin
        ide_nxt.rw   = id_reg_write_en;
        ide_nxt.m2r  = id_mem2reg_sel;
        ide_nxt.mw   = id_mem_write_en;
        ide_nxt.beq  = id_beq;
        ide_nxt.bne  = id_bne;
        ide_nxt.alu  = id_alu_ctrl;
        ide_nxt.src  = id_alu_src;
        ide_nxt.rs   = id_rs;
        ide_nxt.rt   = id_rt;
        if (id_reg_write_en)
          ide_nxt.dest = id_reg_dst ? id_rd : id_rt;
      end
    end
  end

  // stage registers and sticky halt flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ide    <= '0;
      exm    <= '0;
      mwb    <= '0;
      halted <= 1'b0;
    end else begin
      ide      <= ide_nxt;
      exm.rw   <= ide.rw;
      exm.m2r  <= ide.m2r;
      exm.mw   <= ide.mw;
      exm.dest <= ide.dest;
      exm.stop <= ide.stop;
      mwb.rw   <= exm.rw;
      mwb.m2r  <= exm.m2r;
      mwb.dest <= exm.dest;
      mwb.stop <= exm.stop;
      if (mwb.stop)
        halted <= 1'b1;
    end
  end

endmodule
